// File: rtl/addsub64_multicycle_if.sv
// addsub64_multicycle_if
// Operand and result handshake bundle for the multi-cycle 64-bit adder/subtractor.
// The operand side carries A, B, Cin and sub under in_valid/in_ready.
// The result side carries S and Cout under out_valid/out_ready.
// The signed-overflow flag V exists only when OVERFLOW_FLAG_EN is defined.
interface addsub64_multicycle_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic        Cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] S;
    logic        Cout;
`ifdef OVERFLOW_FLAG_EN
    logic        V;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout, V
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout, V
    );
`else
    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout
    );
`endif
endinterface

// File: rtl/addsub64_multicycle.sv
// addsub64_multicycle
// Area-lean 64-bit adder/subtractor. It processes one CHUNK_W-bit slice per clock
// and keeps the carry in a register between slices.
// Operation of each state:
//   IDLE - accept operands; B is pre-inverted for subtraction.
//   BUSY - N = 64/CHUNK_W slice cycles.
//   DONE - hold the registered result until out_ready.
// Optional feature macro: OVERFLOW_FLAG_EN adds the signed-overflow output V.
module addsub64_multicycle #(
    parameter int CHUNK_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub64_multicycle_if.slave bus
);

    localparam int N     = 64 / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH    = $clog2(CHUNK_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [63:0]        a_r;
    logic [63:0]        b_r;
    logic [63:0]        work_r;
    logic [63:0]        s_r;
    logic               carry_r;
    logic               cout_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [5:0]         slice_lsb_s;
    logic [CHUNK_W-1:0] slice_a_s;
    logic [CHUNK_W-1:0] slice_b_s;
    logic [CHUNK_W:0]   slice_sum_s;
    logic [63:0]        work_next_s;
    logic               last_s;

`ifdef OVERFLOW_FLAG_EN
    logic               v_r;
    logic               v_s;
`endif

    // Slice datapath: add the selected slices plus the held carry, and merge the sum into the work word.
    always_comb begin
        slice_lsb_s = 6'(cnt_r) << SH;
        slice_a_s   = a_r[slice_lsb_s +: CHUNK_W];
        slice_b_s   = b_r[slice_lsb_s +: CHUNK_W];
        slice_sum_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{CHUNK_W{1'b0}}, carry_r};
        work_next_s = work_r;
        work_next_s[slice_lsb_s +: CHUNK_W] = slice_sum_s[CHUNK_W-1:0];
        last_s      = (cnt_r == CNT_W'(N - 1));
    end

`ifdef OVERFLOW_FLAG_EN
    // Overflow: carry into bit 63 is a^b^sum at bit 63; XOR it with the carry out of bit 63.
    always_comb begin
        v_s = a_r[63] ^ b_r[63] ^ work_next_s[63] ^ slice_sum_s[CHUNK_W];
    end
`endif

    // Control FSM: operand capture, slice sequencing and the result handshake, with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= 64'd0;
            b_r         <= 64'd0;
            work_r      <= 64'd0;
            s_r         <= 64'd0;
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
`ifdef OVERFLOW_FLAG_EN
            v_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.A;
                        b_r        <= bus.sub ? ~bus.B : bus.B;
                        // Subtraction is A + ~B + 1 - Cin, so the initial carry is ~Cin.
                        carry_r    <= bus.sub ? ~bus.Cin : bus.Cin;
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
                    end
                end
                BUSY: begin
                    work_r  <= work_next_s;
                    carry_r <= slice_sum_s[CHUNK_W];
                    if (last_s) begin
                        s_r         <= work_next_s;
                        cout_r      <= slice_sum_s[CHUNK_W];
`ifdef OVERFLOW_FLAG_EN
                        v_r         <= v_s;
`endif
                        cnt_r       <= {CNT_W{1'b0}};
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.S         = s_r;
    assign bus.Cout      = cout_r;
`ifdef OVERFLOW_FLAG_EN
    assign bus.V         = v_r;
`endif

endmodule

// File: tb/tb_addsub64_multicycle.sv
// tb_addsub64_multicycle
// Directed bench for addsub64_multicycle with a result scoreboard. The golden model is a plain 65-bit adder.
// The V checks are compiled in only when OVERFLOW_FLAG_EN is defined.
module tb_addsub64_multicycle;

    localparam int CHUNK_W = 16;
    localparam int N       = 64 / CHUNK_W;

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    exp_t sb_q[$];
    exp_t held;

    addsub64_multicycle_if bus ();

    addsub64_multicycle #(.CHUNK_W(CHUNK_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t golden(input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sb);
        exp_t        e;
        logic [63:0] bop;
        logic        ci;
        logic [64:0] r;
        bop    = sb ? ~b : b;
        ci     = sb ? ~cin : cin;
        r      = {1'b0, a} + {1'b0, bop} + {64'd0, ci};
        e.s    = r[63:0];
        e.cout = r[64];
        e.v    = (a[63] == bop[63]) && (r[63] != a[63]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sb);
        int g;
        g = 0;
        while (bus.in_ready !== 1'b1 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk1("accept_in_ready", bus.in_ready, 1'b1);
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.sub      = sb;
        bus.in_valid = 1'b1;
        sb_q.push_back(golden(a, b, cin, sb));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A        = ~a;
        bus.B        = ~b;
        bus.Cin      = ~cin;
        bus.sub      = ~sb;
        chk1("busy_in_ready", bus.in_ready, 1'b0);
    endtask

    task automatic wait_result(input string tag, input bit check_lat, output exp_t e);
        int lat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 50);
        chk1({tag, "_out_valid"}, bus.out_valid, 1'b1);
        if (check_lat) chk({tag, "_latency"}, 64'(lat), 64'(N));
        e = sb_q.pop_front();
        chk({tag, "_S"}, bus.S, e.s);
        chk1({tag, "_Cout"}, bus.Cout, e.cout);
`ifdef OVERFLOW_FLAG_EN
        chk1({tag, "_V"}, bus.V, e.v);
`endif
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk1({tag, "_valid_fall"}, bus.out_valid, 1'b0);
        chk1({tag, "_ready_rise"}, bus.in_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sb);
        exp_t e;
        send(a, b, cin, sb);
        wait_result(tag, 1'b1, e);
        release_result(tag);
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = 64'd0;
        bus.B         = 64'd0;
        bus.Cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_in_ready", bus.in_ready, 1'b1);
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_S", bus.S, 64'd0);
        chk1("reset_Cout", bus.Cout, 1'b0);
`ifdef OVERFLOW_FLAG_EN
        chk1("reset_V", bus.V, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_wrap", 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
        run_op("sub_pos", 64'd5, 64'd3, 1'b0, 1'b1);
        run_op("sub_neg", 64'd3, 64'd5, 1'b1, 1'b1);
        run_op("add_cin", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);

        // Backpressure: the result must hold, and new requests are ignored.
        send(64'd5, 64'd3, 1'b0, 1'b1);
        wait_result("bp", 1'b1, held);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.A        = {$urandom(), $urandom()};
            bus.B        = {$urandom(), $urandom()};
            bus.Cin      = bus.A[0];
            bus.sub      = bus.B[0];
            @(posedge clk); #1;
            chk("bp_hold_S", bus.S, held.s);
            chk1("bp_hold_Cout", bus.Cout, held.cout);
            chk1("bp_hold_valid", bus.out_valid, 1'b1);
            chk1("bp_hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        release_result("bp");
        @(posedge clk); #1;
        chk1("bp_not_queued", bus.out_valid, 1'b0);

        // Reset after slice 2 abandons the operation and clears the outputs at once.
        send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_S", bus.S, 64'd0);
        chk1("rst_mid_Cout", bus.Cout, 1'b0);
        chk1("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk1("rst_mid_in_ready", bus.in_ready, 1'b1);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 64'd7, 64'd9, 1'b0, 1'b0);

        run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        run_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        run_op("novf_sub", 64'd5, 64'd3, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            run_op("rand", {$urandom(), $urandom()}, {$urandom(), $urandom()},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
